// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode hand-off and control
// inputs from execute, hazard and debug logic.
interface fetch_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  fsm_state;

  modport master (
    input  stall, branch_taken, branch_target, halt_req, imem_ready, imem_rdata,
    output imem_req, imem_addr, instr, pc_plus4, instr_valid, fault, fsm_state
  );

  modport slave (
    output stall, branch_taken, branch_target, halt_req, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instr, pc_plus4, instr_valid, fault, fsm_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/ready handshake
// and hands instr / PC+4 to decode, with redirect, stall, halt and timeout fault.
//
// state  | meaning
// BOOT   | one cycle after reset before the first request
// FETCH  | issuing requests and accepting instructions
// HALTED | no requests; pending instruction may still drain to decode
// FAULT  | memory timed out; sticky until reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset_n,
  fetch_sequencer_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_instr, w_instr_nxt;
  logic [31:0]   r_pc_plus4, w_pc_plus4_nxt;
  logic          r_instr_valid, w_instr_valid_nxt;
  logic          r_fault, w_fault_nxt;
  logic [CW-1:0] r_count, w_count_nxt;

  logic w_req;
  logic w_accept;
  logic w_redirect;
  logic w_waiting;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_pc_plus4    <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_pc_plus4    <= w_pc_plus4_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_count       <= w_count_nxt;
    end
  end

  always_comb begin
    w_req = (r_state == S_FETCH) && !bus.branch_taken && !(r_instr_valid && bus.stall);
    w_accept   = w_req && bus.imem_ready;
    w_waiting  = w_req && !bus.imem_ready;
    w_redirect = bus.branch_taken && (r_state != S_FAULT);

    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_pc_plus4_nxt    = r_pc_plus4;
    w_instr_valid_nxt = r_instr_valid;
    w_fault_nxt       = r_fault;
    w_count_nxt       = '0;

    case (r_state)
      S_BOOT:   w_state_nxt = S_FETCH;
      S_FETCH: begin
        // a redirect defers the halt decision to the following cycle
        if (!w_redirect) begin
          if (w_waiting && (r_count == TC))
            w_state_nxt = S_FAULT;
          else if (bus.halt_req && (!w_req || w_accept))
            w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (!w_redirect && !bus.halt_req)
          w_state_nxt = S_FETCH;
      end
      default:  w_state_nxt = S_FAULT;
    endcase

    if (w_redirect) begin
      w_pc_nxt          = bus.branch_target & 32'hFFFF_FFFC;
      w_instr_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_instr_nxt       = bus.imem_rdata;
      w_pc_plus4_nxt    = r_pc + 32'd4;
      w_pc_nxt          = r_pc + 32'd4;
      w_instr_valid_nxt = 1'b1;
    end else if (r_instr_valid && !bus.stall) begin
      w_instr_valid_nxt = 1'b0;
    end

    if (w_waiting)
      w_count_nxt = r_count + CW'(1);

    if (w_state_nxt == S_FAULT) begin
      w_instr_valid_nxt = 1'b0;
      w_fault_nxt       = 1'b1;
      w_count_nxt       = '0;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.pc_plus4    = r_pc_plus4;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fault       = r_fault;
  assign bus.fsm_state   = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, wait states, stall, redirect,
// halt, timeout fault, PC wrap and asynchronous reset.
module tb_fetch_sequencer;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory returns its own address as data
  always_comb bus.imem_rdata = bus.imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt_req = 1'b0;
    bus.imem_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_state", 32'(bus.fsm_state), 32'd0);
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc4",   bus.pc_plus4, 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);

    // streaming with ready=1
    reset_n = 1'b1;
    #1;
    chk("boot_state", 32'(bus.fsm_state), 32'd0);
    chk("boot_req",   32'(bus.imem_req), 32'd0);
    tick();
    chk("s1_state", 32'(bus.fsm_state), 32'd1);
    chk("s1_req",   32'(bus.imem_req), 32'd1);
    chk("s1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("s2_valid", 32'(bus.instr_valid), 32'd1);
    chk("s2_instr", bus.instr, 32'h0);
    chk("s2_pc4",   bus.pc_plus4, 32'h4);
    chk("s2_addr",  bus.imem_addr, 32'h4);
    tick();
    chk("s3_instr", bus.instr, 32'h4);
    chk("s3_pc4",   bus.pc_plus4, 32'h8);
    tick();
    chk("s4_instr", bus.instr, 32'h8);
    chk("s4_pc4",   bus.pc_plus4, 32'hC);
    chk("s4_addr",  bus.imem_addr, 32'hC);

    // three wait cycles
    bus.imem_ready = 1'b0;
    tick();
    chk("w1_valid", 32'(bus.instr_valid), 32'd0);
    chk("w1_addr",  bus.imem_addr, 32'hC);
    chk("w1_req",   32'(bus.imem_req), 32'd1);
    tick();
    chk("w2_addr",  bus.imem_addr, 32'hC);
    tick();
    chk("w3_addr",  bus.imem_addr, 32'hC);
    bus.imem_ready = 1'b1;
    tick();
    chk("w4_instr", bus.instr, 32'hC);
    chk("w4_pc4",   bus.pc_plus4, 32'h10);
    chk("w4_valid", 32'(bus.instr_valid), 32'd1);

    // two stall cycles
    bus.stall = 1'b1;
    #1;
    chk("st_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("st1_instr", bus.instr, 32'hC);
    chk("st1_valid", 32'(bus.instr_valid), 32'd1);
    chk("st1_addr",  bus.imem_addr, 32'h10);
    tick();
    chk("st2_instr", bus.instr, 32'hC);
    chk("st2_pc4",   bus.pc_plus4, 32'h10);
    bus.stall = 1'b0;
    tick();
    chk("st3_instr", bus.instr, 32'h10);
    chk("st3_pc4",   bus.pc_plus4, 32'h14);
    chk("st3_addr",  bus.imem_addr, 32'h14);

    // redirect overriding stall, misaligned target
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_0103;
    #1;
    chk("br_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("br_valid", 32'(bus.instr_valid), 32'd0);
    chk("br_addr",  bus.imem_addr, 32'h100);
    chk("br_state", 32'(bus.fsm_state), 32'd1);
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    tick();
    chk("br2_instr", bus.instr, 32'h100);
    chk("br2_pc4",   bus.pc_plus4, 32'h104);

    // halt requested while waiting for ready
    bus.imem_ready = 1'b0;
    bus.halt_req = 1'b1;
    tick();
    chk("h1_state", 32'(bus.fsm_state), 32'd1);
    chk("h1_addr",  bus.imem_addr, 32'h104);
    tick();
    chk("h2_state", 32'(bus.fsm_state), 32'd1);
    bus.imem_ready = 1'b1;
    tick();
    chk("h3_state", 32'(bus.fsm_state), 32'd2);
    chk("h3_instr", bus.instr, 32'h104);
    chk("h3_valid", 32'(bus.instr_valid), 32'd1);
    chk("h3_req",   32'(bus.imem_req), 32'd0);
    tick();
    chk("h4_valid", 32'(bus.instr_valid), 32'd0);
    chk("h4_state", 32'(bus.fsm_state), 32'd2);
    chk("h4_addr",  bus.imem_addr, 32'h108);
    bus.halt_req = 1'b0;
    tick();
    chk("h5_state", 32'(bus.fsm_state), 32'd1);
    tick();
    chk("h6_instr", bus.instr, 32'h108);
    chk("h6_pc4",   bus.pc_plus4, 32'h10C);

    // redirect to top of memory, wrap of PC+4
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.branch_taken = 1'b0;
    tick();
    chk("wr_instr", bus.instr, 32'hFFFF_FFFC);
    chk("wr_pc4",   bus.pc_plus4, 32'h0);
    chk("wr_addr2", bus.imem_addr, 32'h0);

    // async reset mid-wait
    bus.imem_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("ar_state", 32'(bus.fsm_state), 32'd0);
    chk("ar_instr", bus.instr, 32'h0);
    chk("ar_pc4",   bus.pc_plus4, 32'h0);
    chk("ar_req",   32'(bus.imem_req), 32'd0);
    tick();
    reset_n = 1'b1;

    // timeout fault with ready held low
    tick();
    chk("to0_state", 32'(bus.fsm_state), 32'd1);
    repeat (15) tick();
    chk("to15_state", 32'(bus.fsm_state), 32'd1);
    chk("to15_fault", 32'(bus.fault), 32'd0);
    tick();
    chk("to16_state", 32'(bus.fsm_state), 32'd3);
    chk("to16_fault", 32'(bus.fault), 32'd1);
    chk("to16_req",   32'(bus.imem_req), 32'd0);
    chk("to16_valid", 32'(bus.instr_valid), 32'd0);
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h0000_0200;
    tick();
    chk("fb_addr",  bus.imem_addr, 32'h0);
    chk("fb_state", 32'(bus.fsm_state), 32'd3);
    bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b1;
    tick();
    chk("fs_fault", 32'(bus.fault), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("fr_fault", 32'(bus.fault), 32'd0);
    chk("fr_state", 32'(bus.fsm_state), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rc_state", 32'(bus.fsm_state), 32'd1);
    tick();
    chk("rc_instr", bus.instr, 32'h0);
    chk("rc_pc4",   bus.pc_plus4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
